// File: rtl/npu_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package npu_pkg;
  localparam int AW_DEF        = 10;
  localparam int DW_DEF        = 8;
  localparam int RD_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } arb_state_e;
endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry FIFO holding stream read beats (data plus last-beat flag).
module sram_rd_fifo
  import npu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_last_i,
  input  logic          pop_i,
  output logic [1:0]    count_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o
);
  logic [DW-1:0] data_q [RD_FIFO_DEPTH];
  logic          last_q [RD_FIFO_DEPTH];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      data_q[wr_ptr_q] <= push_data_i;
      last_q[wr_ptr_q] <= push_last_i;
    end
  end

  // Storage is not reset, so outputs are masked until an entry is valid.
  assign count_o = cnt_q;
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = valid_o ? data_q[rd_ptr_q] : '0;
  assign last_o  = valid_o & last_q[rd_ptr_q];
endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM shared between a host port and a stream burst reader,
// round-robin arbitrated, with a 2-deep read-beat FIFO on the stream side.
module sram_arbiter
  import npu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  input  logic          s_start,
  input  logic [AW-1:0] s_base,
  input  logic [AW:0]   s_len,
  output logic          s_busy,
  output logic          s_done,
  output logic          s_valid,
  output logic [DW-1:0] s_data,
  output logic          s_last,
  input  logic          s_ready,
  output logic          m_ce,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout
);
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  arb_state_e    state_q, state_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [AW:0]   remain_q, remain_d;
  logic          rr_q, rr_d;
  logic          h_rd_q, s_rd_q, s_rd_last_q;
  logic [1:0]    fifo_cnt;
  logic          fifo_pop;
  logic          host_elig, strm_elig, host_gnt, strm_gnt;

  // rr_q=0 gives the host priority on the next contested cycle.
  always_comb begin
    host_elig = h_req & rst_n;
    strm_elig = (state_q == ST_STREAM) && (remain_q != '0) &&
                ((fifo_cnt + {1'b0, s_rd_q}) < 2'(RD_FIFO_DEPTH));
    host_gnt  = host_elig && !(strm_elig && rr_q);
    strm_gnt  = strm_elig && !(host_elig && !rr_q);
    rr_d      = rr_q;
    if (host_elig && strm_elig) rr_d = ~rr_q;
  end

  always_comb begin
    state_d  = state_q;
    s_addr_d = s_addr_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (s_start) begin
          if (s_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_STREAM;
            s_addr_d = s_base;
            remain_d = (s_len > MAX_LEN) ? MAX_LEN : s_len;
          end
        end
      end
      ST_STREAM: begin
        if (strm_gnt) begin
          s_addr_d = s_addr_q + AW'(1);
          remain_d = remain_q - (AW+1)'(1);
          if (remain_q == (AW+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (fifo_pop && s_last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      rr_q        <= 1'b0;
      h_rd_q      <= 1'b0;
      s_rd_q      <= 1'b0;
      s_rd_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      rr_q        <= rr_d;
      h_rd_q      <= host_gnt & ~h_we;
      s_rd_q      <= strm_gnt;
      s_rd_last_q <= strm_gnt && (remain_q == (AW+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    s_addr_q <= s_addr_d;
  end

  assign fifo_pop = s_valid & s_ready;

  sram_rd_fifo #(.DW(DW)) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (s_rd_q),
    .push_data_i (m_dout),
    .push_last_i (s_rd_last_q),
    .pop_i       (fifo_pop),
    .count_o     (fifo_cnt),
    .valid_o     (s_valid),
    .data_o      (s_data),
    .last_o      (s_last)
  );

  assign h_gnt    = host_gnt;
  assign h_rvalid = h_rd_q;
  assign h_rdata  = h_rd_q ? m_dout : '0;
  assign s_busy   = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign s_done   = (state_q == ST_DONE);
  assign m_ce     = host_gnt | strm_gnt;
  assign m_we     = host_gnt & h_we;
  assign m_addr   = host_gnt ? h_addr : (strm_gnt ? s_addr_q : '0);
  assign m_din    = (host_gnt && h_we) ? h_wdata : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-level model.
module tb_sram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic h_req, h_we, h_gnt, h_rvalid;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata, h_rdata;
  logic s_start, s_busy, s_done, s_valid, s_last, s_ready;
  logic [AW-1:0] s_base;
  logic [AW:0] s_len;
  logic [DW-1:0] s_data;
  logic m_ce, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_dout;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .s_start(s_start), .s_base(s_base), .s_len(s_len),
    .s_busy(s_busy), .s_done(s_done), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready),
    .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 151 + 29) ^ (i >> 3));
  endfunction

  // SRAM behavioural model: registered read data, write on m_we.
  logic [DW-1:0] mem [1024];
  bit sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      sram_init <= 1'b1;
    end else if (m_ce) begin
      if (m_we) mem[m_addr] <= m_din;
      else      m_dout <= mem[m_addr];
    end
  end

  // Reference model state
  logic [7:0] ref_mem [1024];
  bit  ref_init = 1'b0;
  bit  busy_now, done_now, busy_nx, done_nx, idle_now;
  bit  pend_hrd, hgnt_seen, done_seen;
  logic [7:0] pend_hdata, last_rdata;
  int  base_m, len_m, s_issued, s_popped, hwait, mce_cnt, hgnt_cnt;
  bit  prev_v, prev_r, prev_l;
  logic [7:0] prev_d;

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      busy_now = 0; done_now = 0; pend_hrd = 0; prev_v = 0;
      hwait = 0; hgnt_seen = 0;
    end else begin
      hgnt_seen = h_gnt;
      chk("h_rvalid", h_rvalid, pend_hrd);
      if (pend_hrd) chk("h_rdata", h_rdata, pend_hdata);
      if (h_rvalid) last_rdata = h_rdata;
      pend_hrd = h_gnt && !h_we;
      if (h_gnt) begin
        hgnt_cnt++;
        chk("h_latency_ok", hwait < 2, 1);
        hwait = 0;
        chk("h_mport", {m_ce, m_we, m_addr}, {1'b1, h_we, h_addr});
        if (h_we) begin
          chk("h_din", m_din, h_wdata);
          ref_mem[h_addr] = h_wdata;
        end else begin
          pend_hdata = ref_mem[h_addr];
        end
      end else if (h_req) hwait++;
      else hwait = 0;

      if (!m_ce) chk("m_we_idle", m_we, 0);
      else mce_cnt++;

      chk("s_busy", s_busy, busy_now);
      chk("s_done", s_done, done_now);
      if (s_done) done_seen = 1;
      idle_now = !busy_now && !done_now;
      busy_nx = busy_now;
      done_nx = 0;

      if (m_ce && !h_gnt) begin
        chk("s_rd_in_burst", busy_now, 1);
        chk("s_rd_addr", {m_we, m_addr}, (base_m + s_issued) % 1024);
        s_issued++;
        chk("s_outstanding_ok", (s_issued - s_popped) <= 2, 1);
        chk("s_no_overrun", s_issued <= len_m, 1);
      end

      if (!busy_now) chk("s_valid_idle", s_valid, 0);
      else if (s_valid) begin
        chk("s_no_overpop", s_popped < len_m, 1);
        chk("s_data", s_data, ref_mem[(base_m + s_popped) % 1024]);
        chk("s_last", s_last, s_popped == len_m - 1);
      end
      if (prev_v && !prev_r) chk("s_stable", {s_valid, s_last, s_data}, {1'b1, prev_l, prev_d});
      prev_v = s_valid; prev_r = s_ready; prev_d = s_data; prev_l = s_last;

      if (busy_now && s_valid && s_ready) begin
        s_popped++;
        if (s_popped == len_m) begin busy_nx = 0; done_nx = 1; end
      end
      if (idle_now && s_start) begin
        base_m = int'(s_base);
        len_m = (s_len > 11'd1024) ? 1024 : int'(s_len);
        s_issued = 0;
        s_popped = 0;
        if (len_m == 0) done_nx = 1;
        else busy_nx = 1;
      end
      busy_now = busy_nx;
      done_now = done_nx;
    end
  end

  // Stimulus
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} hop_t;
  hop_t host_q[$];
  int host_mode, rdy_mode;

  function automatic logic [63:0] outs();
    return {h_gnt, h_rvalid, h_rdata, s_busy, s_done, s_valid, s_data, s_last,
            m_ce, m_we, m_addr, m_din};
  endfunction

  task automatic cycle();
    hop_t op;
    @(posedge clk); #1;
    s_start = 1'b0;
    if (h_req && hgnt_seen) h_req = 1'b0;
    if (!h_req) begin
      if (host_q.size() > 0) begin
        op = host_q.pop_front();
        h_req = 1'b1; h_we = op.we; h_addr = op.addr; h_wdata = op.data;
      end else if (host_mode == 2 || (host_mode == 1 && $urandom_range(0, 2) == 0)) begin
        h_req = 1'b1; h_we = 1'b0; h_addr = AW'($urandom); h_wdata = '0;
      end
    end
    case (rdy_mode)
      0:       s_ready = 1'b1;
      1:       s_ready = 1'($urandom_range(0, 1));
      default: s_ready = 1'b0;
    endcase
  endtask

  task automatic wait_host_idle();
    int i;
    for (i = 0; i < 100 && (h_req || host_q.size() > 0); i++) cycle();
    chk("host_idle", !h_req && host_q.size() == 0, 1);
    repeat (3) cycle();
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    done_seen = 0;
    cycle();
    s_start = 1'b1; s_base = b; s_len = l;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) cycle();
    chk("done_seen", done_seen, 1);
  endtask

  int mark, hmark;

  initial begin
    rst_n = 1'b0; h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    s_start = 0; s_base = '0; s_len = '0; s_ready = 1'b1;
    host_mode = 0; rdy_mode = 0; mce_cnt = 0; hgnt_cnt = 0;
    repeat (3) @(posedge clk);
    #1 chk("rst_outs", outs(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) cycle();

    // host write then read back
    host_q.push_back('{1'b1, 10'h010, 8'hA5});
    host_q.push_back('{1'b0, 10'h010, 8'h00});
    wait_host_idle();
    chk("t039_rdata", last_rdata, 8'hA5);

    // burst across the address wrap
    start_burst(10'h3FE, 11'd4);
    wait_done(100);
    chk("t040_reads", s_issued, 4);
    chk("t040_beats", s_popped, 4);

    // burst with continuous host reads
    host_mode = 2; hmark = hgnt_cnt;
    start_burst(10'h100, 11'd8);
    wait_done(200);
    host_mode = 0;
    wait_host_idle();
    chk("t041_beats", s_popped, 8);
    chk("t041_host_progress", (hgnt_cnt - hmark) >= 8, 1);

    // consumer stall
    rdy_mode = 2;
    start_burst(10'h200, 11'd6);
    repeat (10) cycle();
    chk("t042_issued_le2", s_issued <= 2, 1);
    chk("t042_valid_held", s_valid, 1);
    rdy_mode = 0;
    wait_done(100);
    chk("t042_beats", s_popped, 6);

    // zero length, then start ignored while busy
    mark = mce_cnt;
    start_burst(10'h050, 11'd0);
    wait_done(10);
    chk("t043_no_mce", mce_cnt - mark, 0);
    rdy_mode = 1;
    start_burst(10'h300, 11'd5);
    repeat (2) cycle();
    s_start = 1'b1; s_base = 10'h123; s_len = 11'd3;
    wait_done(200);
    chk("t043_len_kept", s_popped, 5);

    // oversize length clamps to a full wrap of the array
    rdy_mode = 0;
    start_burst(10'h3F0, 11'h7FF);
    wait_done(3000);
    chk("clamp_beats", s_popped, 1024);

    // reset mid-burst
    rdy_mode = 2;
    start_burst(10'h010, 11'd8);
    repeat (5) cycle();
    rst_n = 1'b0;
    #1 chk("t044_outs", outs(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rdy_mode = 0; done_seen = 0;
    repeat (20) cycle();
    chk("t044_no_done", done_seen, 0);

    // randomized bursts mixed with idle-time host writes
    for (int it = 0; it < 25; it++) begin
      host_mode = 0;
      for (int k = 0; k < 3; k++) begin
        host_q.push_back('{1'b1, AW'($urandom), DW'($urandom)});
        host_q.push_back('{1'b0, AW'($urandom), 8'h00});
      end
      wait_host_idle();
      host_mode = $urandom_range(0, 2);
      rdy_mode = $urandom_range(0, 1);
      start_burst(AW'($urandom), ($urandom_range(0, 6) == 0) ? 11'd0 : 11'($urandom_range(1, 24)));
      wait_done(1000);
    end
    host_mode = 0;
    wait_host_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 10, SRAM address width (1024 words).
REQ-002 Parameter DW, default 8, SRAM data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 h_req  input  1  host access request; held until h_gnt.
REQ-006 h_we  input  1  host access is a write (1) or read (0).
REQ-007 h_addr  input  AW  host word address.
REQ-008 h_wdata  input  DW  host write data.
REQ-009 h_gnt  output  1  host access issued this cycle.
REQ-010 h_rvalid  output  1  host read data valid (one-cycle pulse).
REQ-011 h_rdata  output  DW  host read data.
REQ-012 s_start  input  1  start a stream burst read.
REQ-013 s_base  input  AW  burst start address.
REQ-014 s_len  input  AW+1  burst length in words.
REQ-015 s_busy  output  1  burst in progress.
REQ-016 s_done  output  1  burst complete (one-cycle pulse).
REQ-017 s_valid / s_data(DW) / s_last  output  stream data beat, last-beat flag.
REQ-018 s_ready  input  1  stream consumer accepts beat.
REQ-019 m_ce, m_we (1), m_addr (AW), m_din (DW)  output  SRAM port controls.
REQ-020 m_dout  input  DW  SRAM read data, valid the cycle after m_ce with m_we=0.

Function
REQ-021 At most one SRAM access per cycle; m_ce=1 only in a granted cycle, otherwise m_ce=0, m_we=0.
REQ-022 Host eligible when h_req=1; stream eligible in STREAM with words remaining and (FIFO count + reads in flight) < 2.
REQ-023 Both eligible: round-robin, pointer moves to the other requester after each contested grant; after reset host wins first.
REQ-024 h_gnt combinational, asserted in the same cycle as the host's m_ce; host write drives m_we=1, m_din=h_wdata.
REQ-025 Host read: h_rvalid=1 and h_rdata=m_dout exactly one cycle after the grant; no h_rvalid for writes.
REQ-026 States: IDLE, STREAM (issuing reads), DRAIN (all issued, FIFO non-empty), DONE (one cycle) -> IDLE.
REQ-027 s_start accepted only in IDLE; ignored in any other state; s_base/s_len latched on acceptance.
REQ-028 s_len=0: IDLE -> DONE, no SRAM reads; s_len>1024 is clamped to 1024.
REQ-029 Burst word i read from (s_base+i) mod 2^AW; address wraps 1023 -> 0.
REQ-030 Stream read data written into a 2-entry FIFO the cycle after its grant; s_valid = FIFO non-empty; pop on s_valid & s_ready.
REQ-031 s_data/s_valid/s_last stable while s_valid=1 and s_ready=0; s_last=1 only on the final burst beat.
REQ-032 s_busy=1 in STREAM and DRAIN; s_done=1 in DONE only, the cycle after the last beat is popped.
REQ-033 Host access to a burst address mid-burst: result follows grant order; no forwarding or hazard stall.
REQ-034 Host throughput guaranteed: a pending h_req is granted within 2 cycles.

Reset
REQ-035 rst_n=0 asynchronously: state IDLE, FIFO empty, in-flight flags clear, RR pointer = host, all outputs 0.
REQ-036 Reset mid-burst abandons the burst; no s_done is produced for it.

Structure
REQ-037 State enum, AW/DW defaults and the FIFO depth constant (2) live in a shared package, npu_pkg.
REQ-038 The 2-entry output FIFO is one sub-module, sram_rd_fifo; arbitration and FSM stay in sram_arbiter.

Verification
REQ-039 Host write 0xA5 to addr 0x010, then read 0x010 -> h_rvalid one cycle after grant, h_rdata=0xA5.
REQ-040 Burst s_base=0x3FE, s_len=4, s_ready=1 -> reads 0x3FE,0x3FF,0x000,0x001 in order, s_last on 4th beat, s_done next cycle.
REQ-041 Burst len 8 with continuous h_req reads -> grants alternate host/stream, every host read completes within 2 cycles.
REQ-042 Burst len 6, s_ready=0 for 10 cycles -> at most 2 reads issued, s_valid/s_data stable, no data lost after release.
REQ-043 s_len=0 -> s_done one cycle later, m_ce never asserted; s_start during a burst -> ignored.
REQ-044 rst_n low mid-burst -> all outputs 0 immediately, state IDLE, no s_done after release.
